// File: rtl/alu_mac_pipe.sv
// Two-stage lane ALU (ADD/SUB/MUL/MAC) with a persistent accumulator.
// S1 holds the accepted operands; S2 holds the result, the flags and v_o.
module alu_mac_pipe #(
  parameter int unsigned vdw_p      = 32,
  parameter int unsigned op_width_p = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic [vdw_p-1:0]      a_i,
  input  logic [vdw_p-1:0]      b_i,
  input  logic [op_width_p-1:0] op_i,
  input  logic                  acc_clr_i,
  output logic                  v_o,
  input  logic                  yumi_i,
  output logic [vdw_p-1:0]      result_o,
  output logic                  flag_overflow_o,
  output logic                  flag_zero_o,
  output logic                  flag_negative_o,
  output logic [vdw_p-1:0]      acc_o
);

  typedef enum logic [op_width_p-1:0] {
    OP_ADD = op_width_p'(0),
    OP_SUB = op_width_p'(1),
    OP_MUL = op_width_p'(2),
    OP_MAC = op_width_p'(3)
  } op_e;

  // Stage 1 registers
  logic             v1_q, v1_d;
  logic [vdw_p-1:0] a1_q, b1_q;
  op_e              op1_q;
  logic             clr1_q;

  // Stage 2 registers
  logic             v2_q, v2_d;
  logic [vdw_p-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, neg_q;
  logic [vdw_p-1:0] acc_q, acc_d;

  logic                 s2_en;
  logic                 accept;
  logic [2*vdw_p-1:0]   prod;
  logic [vdw_p:0]       sum;
  logic [vdw_p-1:0]     acc_base;

  assign s2_en   = v1_q & (~v2_q | yumi_i);
  assign ready_o = ~v1_q | s2_en;
  assign accept  = v_i & ready_o;

  assign v1_d = accept | (v1_q & ~s2_en);
  assign v2_d = s2_en | (v2_q & ~yumi_i);

  assign prod     = {{vdw_p{1'b0}}, a1_q} * {{vdw_p{1'b0}}, b1_q};
  assign acc_base = clr1_q ? '0 : acc_q;

  // Result, overflow and accumulator next-state from the S1 operands
  always_comb begin
    sum   = '0;
    res_d = '0;
    ovf_d = 1'b0;
    acc_d = acc_q;
    case (op1_q)
      OP_ADD: begin
        sum   = {1'b0, a1_q} + {1'b0, b1_q};
        res_d = sum[vdw_p-1:0];
        ovf_d = sum[vdw_p];
      end
      OP_SUB: begin
        sum   = {1'b0, a1_q} + {1'b0, ~b1_q} + (vdw_p+1)'(1);
        res_d = sum[vdw_p-1:0];
        ovf_d = ~sum[vdw_p];
      end
      OP_MUL: begin
        res_d = prod[vdw_p-1:0];
        ovf_d = |prod[2*vdw_p-1:vdw_p];
      end
      OP_MAC: begin
        sum   = {1'b0, acc_base} + {1'b0, prod[vdw_p-1:0]};
        res_d = sum[vdw_p-1:0];
        ovf_d = sum[vdw_p];
        if (s2_en) acc_d = sum[vdw_p-1:0];
      end
      default: begin
        res_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  // Stage 1: capture operands when an op is accepted
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      op1_q  <= OP_ADD;
      clr1_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      if (accept) begin
        a1_q   <= a_i;
        b1_q   <= b_i;
        op1_q  <= op_e'(op_i);
        clr1_q <= acc_clr_i;
      end
    end
  end

  // Stage 2: register result, flags and accumulator when S1 advances
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v2_q   <= 1'b0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      v2_q  <= v2_d;
      acc_q <= acc_d;
      if (s2_en) begin
        res_q  <= res_d;
        ovf_q  <= ovf_d;
        zero_q <= (res_d == '0);
        neg_q  <= res_d[vdw_p-1];
      end
    end
  end

  assign v_o             = v2_q;
  assign result_o        = res_q;
  assign flag_overflow_o = ovf_q;
  assign flag_zero_o     = zero_q;
  assign flag_negative_o = neg_q;
  assign acc_o           = acc_q;

endmodule

// File: tb/tb_alu_mac_pipe.sv
// Scoreboard bench for alu_mac_pipe at 8-bit lane width.
module tb_alu_mac_pipe;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset_i, v_i, ready_o, acc_clr_i, v_o, yumi_i;
  logic [W-1:0] a_i, b_i, result_o, acc_o;
  logic [1:0]   op_i;
  logic         flag_overflow_o, flag_zero_o, flag_negative_o;

  alu_mac_pipe #(.vdw_p(W), .op_width_p(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .op_i(op_i), .acc_clr_i(acc_clr_i),
    .v_o(v_o), .yumi_i(yumi_i), .result_o(result_o),
    .flag_overflow_o(flag_overflow_o), .flag_zero_o(flag_zero_o),
    .flag_negative_o(flag_negative_o), .acc_o(acc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int ovf;
    int z;
    int n;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_m = 0;
  int   yumi_mode = 1;   // 0 never, 1 always, 2 random

  // Reference: plain integer arithmetic, accumulator advanced in program order
  function automatic exp_t model(int op, int a, int b, int clr);
    exp_t e;
    int   s;
    case (op)
      0: begin s = a + b; e.r = s % M; e.ovf = (s >= M) ? 1 : 0; end
      1: begin e.r = (a - b + M) % M; e.ovf = (a < b) ? 1 : 0; end
      2: begin s = a * b; e.r = s % M; e.ovf = (s >= M) ? 1 : 0; end
      default: begin
        s = (clr != 0 ? 0 : acc_m) + (a * b) % M;
        e.r = s % M; e.ovf = (s >= M) ? 1 : 0;
        acc_m = e.r;
      end
    endcase
    e.z   = (e.r == 0) ? 1 : 0;
    e.n   = (e.r >= M / 2) ? 1 : 0;
    e.acc = acc_m;
    return e;
  endfunction

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Consumer: decide yumi shortly after each edge, only while v_o is up
  always @(posedge clk) begin
    #1;
    case (yumi_mode)
      0:       yumi_i = 1'b0;
      1:       yumi_i = v_o;
      default: yumi_i = v_o && ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: check hold-while-stalled and pop/compare each retired result
  logic         held = 1'b0;
  logic [W-1:0] held_r;
  logic [2:0]   held_f;
  always @(negedge clk) begin
    if (reset_i) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_v", int'(v_o), 1);
        chk("hold_result", int'(result_o), int'(held_r));
        chk("hold_flags", int'({flag_overflow_o, flag_zero_o, flag_negative_o}), int'(held_f));
      end
      held   = v_o && !yumi_i;
      held_r = result_o;
      held_f = {flag_overflow_o, flag_zero_o, flag_negative_o};
      if (v_o && yumi_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", int'(result_o), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", int'(result_o), e.r);
          chk("ovf", int'(flag_overflow_o), e.ovf);
          chk("zero", int'(flag_zero_o), e.z);
          chk("neg", int'(flag_negative_o), e.n);
          chk("acc", int'(acc_o), e.acc);
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  // Present one op (called just after an edge) until accepted, bounded
  task automatic issue(int op, int a, int b, int clr);
    bit got;
    int n;
    got = 0;
    n   = 0;
    v_i = 1'b1; op_i = 2'(op); a_i = W'(a); b_i = W'(b); acc_clr_i = (clr != 0);
    while (!got && n < 50) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1;
        sb.push_back(model(op, a, b, clr));
      end
      step();
      n++;
    end
    v_i = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int base;
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
    a_i = '0; b_i = '0; op_i = '0; acc_clr_i = 1'b0;
    repeat (3) step();
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_v_o", int'(v_o), 0);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_result", int'(result_o), 0);
    chk("rst_flags", int'({flag_overflow_o, flag_zero_o, flag_negative_o}), 0);
    chk("rst_acc", int'(acc_o), 0);
    step();

    // ADD 0xFF+0x01 with latency: v_o rises after the second edge
    issue(0, 8'hFF, 8'h01, 0);
    @(negedge clk);
    chk("lat_edge1_v_o", int'(v_o), 0);
    @(negedge clk);
    chk("lat_edge2_v_o", int'(v_o), 1);
    chk("add_ff_res", int'(result_o), 0);
    chk("add_ff_ovf", int'(flag_overflow_o), 1);
    chk("add_ff_zero", int'(flag_zero_o), 1);
    chk("add_ff_neg", int'(flag_negative_o), 0);
    step();

    issue(1, 5, 7, 0);
    issue(1, 7, 5, 0);
    issue(2, 16, 16, 0);
    issue(2, 15, 17, 0);
    drain();

    // Back-to-back MACs then ADD on consecutive cycles
    base = pop_cyc.size();
    issue(3, 3, 4, 1);
    issue(3, 2, 5, 0);
    issue(3, 1, 1, 0);
    issue(0, 1, 1, 0);
    drain();
    repeat (2) step();
    chk("mac_seq_count", pop_cyc.size() - base, 4);
    if (pop_cyc.size() - base == 4)
      chk("mac_seq_consecutive", pop_cyc[base+3] - pop_cyc[base], 3);
    chk("mac_seq_acc", int'(acc_o), 23);

    // Backpressure: consumer stalled, two ops fit, third is refused
    yumi_mode = 0;
    step();
    base = pop_cyc.size();
    issue(0, 1, 2, 0);
    issue(0, 3, 4, 0);
    v_i = 1'b1; op_i = 2'd0; a_i = 8'd5; b_i = 8'd6; acc_clr_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", int'(ready_o), 0);
      chk("bp_v_o", int'(v_o), 1);
      chk("bp_result", int'(result_o), 3);
      step();
    end
    yumi_mode = 1;
    issue(0, 5, 6, 0);
    issue(0, 7, 8, 0);
    drain();
    repeat (2) step();
    chk("bp_retired", pop_cyc.size() - base, 4);

    // Reset with two MACs in flight
    yumi_mode = 0;
    step();
    issue(3, 3, 3, 1);
    issue(3, 2, 2, 0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    sb.delete();
    acc_m = 0;
    @(negedge clk);
    chk("mid_rst_v_o", int'(v_o), 0);
    chk("mid_rst_acc", int'(acc_o), 0);
    chk("mid_rst_ready", int'(ready_o), 1);
    step();
    yumi_mode = 1;
    issue(3, 2, 3, 0);
    drain();
    chk("post_rst_mac_acc", int'(acc_o), 6);

    // Randomized traffic with random consumer stalls
    yumi_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) step();
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, M - 1)),
            int'($urandom_range(0, M - 1)), ($urandom_range(0, 5) == 0) ? 1 : 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
